hazard_fwd_ctrl: RTL and testbench



---
 rtl/hazard_fwd_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
//   Combined hazard-detection and forwarding controller for the 5-stage MIPS
//   pipeline. It adds a variable-latency data-memory handshake with timeout,
//   multi-cycle EX operations, branch-flush arbitration and a saturating
//   stall-cycle counter.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   id_*                     IF/ID source specifiers, use flags, valid
//   branch_taken             branch resolved taken in ID
//   ex_rs/ex_rt/ex_rd        ID/EX specifiers
//   ex_mem_read              ID/EX holds a load
//   ex_long_start            a long op enters EX this cycle
//   mem_rd/mem_reg_write     EX/MEM destination and write enable
//   mem_req/mem_ready        data-memory request and completion
//   wb_rd/wb_reg_write       MEM/WB destination and write enable
//   cnt_clr                  clear the stall counter
//   fwd_a/fwd_b              EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   pc_load, ifid_ld         PC and IF/ID load enables
//   idex_bubble, ifid_flush  NOP insertion into ID/EX, zeroing of IF/ID
//   stall_all                freeze every pipeline register
//   mem_abort, mem_err       timeout pulse, sticky timeout flag
//   stall_cycles             saturating count of cycles with pc_load=0
module hazard_fwd_ctrl #(
    parameter int REG_W       = 5,
    parameter int LONG_LAT    = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             branch_taken,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_long_start,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic             cnt_clr,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_load,
    output logic             ifid_ld,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             stall_all,
    output logic             mem_abort,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int LONG_W = (LONG_LAT > 2) ? $clog2(LONG_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [LONG_W-1:0] LONG_FIRST = LONG_W'(LONG_LAT - 1);
    localparam logic [LONG_W-1:0] LONG_LAST  = LONG_W'(1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        LONG_BUSY = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [LONG_W-1:0] long_cnt, long_nxt;
    logic              err_nxt;

    logic       stall, abort, load_use, flush;
    logic       lu_hit;
    logic [1:0] fa, fb;

    // Forwarding: EX/MEM has priority over MEM/WB; register 0 never forwards.
    always_comb begin
        fa = 2'b00;
        fb = 2'b00;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs))
            fa = 2'b10;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs))
            fa = 2'b01;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rt))
            fb = 2'b10;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rt))
            fb = 2'b01;
    end

    assign lu_hit = id_valid && ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs && (ex_rd == id_rs)) ||
                     (id_use_rt && (ex_rd == id_rt)));

    // Next-state and stall arbitration
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        long_nxt  = long_cnt;
        err_nxt   = mem_err;
        stall     = 1'b0;
        abort     = 1'b0;
        load_use  = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    stall     = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    load_use = lu_hit;
                    if (ex_long_start) begin
                        state_nxt = LONG_BUSY;
                        long_nxt  = LONG_FIRST;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    // Release the freeze on the abort cycle so the pipeline
                    // drains instead of hanging on a dead memory.
                    abort     = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else begin
                    stall    = 1'b1;
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            LONG_BUSY: begin
                stall    = 1'b1;
                long_nxt = long_cnt - 1'b1;
                if (long_cnt == LONG_LAST) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        // A taken branch waits while anything holds IF/ID; it re-requests.
        flush = !stall && !load_use && branch_taken && id_valid;
    end

    // Output drive; reset forces the free-running defaults.
    always_comb begin
        fwd_a       = fa;
        fwd_b       = fb;
        stall_all   = stall;
        mem_abort   = abort;
        pc_load     = !(stall || load_use);
        ifid_ld     = !(stall || load_use);
        idex_bubble = load_use;
        ifid_flush  = flush;
        if (rst) begin
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
            stall_all   = 1'b0;
            mem_abort   = 1'b0;
            pc_load     = 1'b1;
            ifid_ld     = 1'b1;
            idex_bubble = 1'b0;
            ifid_flush  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            long_cnt     <= '0;
            mem_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            long_cnt <= long_nxt;
            mem_err  <= err_nxt;
            if (cnt_clr)
                stall_cycles <= '0;
            else if (!pc_load && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl
//   Directed plan sequences followed by randomized cycles, every output checked
//   each cycle against a behavioural model built from remaining-freeze counts.
module tb_hazard_fwd_ctrl;

    localparam int RW  = 5;
    localparam int LAT = 4;
    localparam int TO  = 8;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_use_rs, id_use_rt, branch_taken;
    logic [RW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic          ex_mem_read, ex_long_start, mem_reg_write, mem_req, mem_ready;
    logic          wb_reg_write, cnt_clr;
    logic [1:0]    fwd_a, fwd_b;
    logic          pc_load, ifid_ld, idex_bubble, ifid_flush, stall_all;
    logic          mem_abort, mem_err;
    logic [CW-1:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    // model state
    int m_long_left;   // frozen cycles still owed to a long op
    int m_mem_wait;    // cycles already spent waiting on memory (0 = none)
    int m_err;
    int m_cnt;

    hazard_fwd_ctrl #(.REG_W(RW), .LONG_LAT(LAT), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .branch_taken(branch_taken),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_long_start(ex_long_start),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .cnt_clr(cnt_clr),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_load(pc_load), .ifid_ld(ifid_ld),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .stall_all(stall_all),
        .mem_abort(mem_abort), .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int fwd_model(input int src);
        if (mem_reg_write && mem_rd != 0 && int'(mem_rd) == src) return 2;
        if (wb_reg_write && wb_rd != 0 && int'(wb_rd) == src) return 1;
        return 0;
    endfunction

    // Called with clk low and inputs set; checks, then advances one edge.
    task automatic apply_cycle();
        int  e_fa, e_fb, e_stall, e_abort, e_lu, e_flush, e_pc;
        bit  running, hit;
        #1;
        e_fa = fwd_model(int'(ex_rs));
        e_fb = fwd_model(int'(ex_rt));
        e_abort = 0;
        running = (m_long_left == 0) && (m_mem_wait == 0);
        if (m_long_left > 0)      e_stall = 1;
        else if (m_mem_wait > 0) begin
            if (mem_ready)                 e_stall = 0;
            else if (m_mem_wait == TO - 1) begin e_stall = 0; e_abort = 1; end
            else                           e_stall = 1;
        end else                  e_stall = (mem_req && !mem_ready) ? 1 : 0;
        hit = id_valid && ex_mem_read && ex_rd != 0 &&
              ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
        e_lu    = (running && e_stall == 0 && hit) ? 1 : 0;
        e_flush = (e_stall == 0 && e_lu == 0 && branch_taken && id_valid) ? 1 : 0;
        if (rst) begin
            e_fa = 0; e_fb = 0; e_stall = 0; e_abort = 0; e_lu = 0; e_flush = 0;
        end
        e_pc = (e_stall == 0 && e_lu == 0) ? 1 : 0;

        check("fwd_a", int'(fwd_a), e_fa);
        check("fwd_b", int'(fwd_b), e_fb);
        check("stall_all", int'(stall_all), e_stall);
        check("mem_abort", int'(mem_abort), e_abort);
        check("pc_load", int'(pc_load), e_pc);
        check("ifid_ld", int'(ifid_ld), e_pc);
        check("idex_bubble", int'(idex_bubble), e_lu);
        check("ifid_flush", int'(ifid_flush), e_flush);
        check("mem_err", int'(mem_err), m_err);
        check("stall_cycles", int'(stall_cycles), m_cnt);

        @(posedge clk);
        if (rst) begin
            m_long_left = 0; m_mem_wait = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (m_long_left > 0) m_long_left--;
            else if (m_mem_wait > 0) begin
                if (mem_ready || e_abort == 1) m_mem_wait = 0;
                else                           m_mem_wait++;
                if (e_abort == 1) m_err = 1;
            end else if (e_stall == 1) m_mem_wait = 1;
            else if (ex_long_start)    m_long_left = LAT - 1;
            if (cnt_clr)                             m_cnt = 0;
            else if (e_pc == 0 && m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 0; id_valid = 0; id_use_rs = 0; id_use_rt = 0; branch_taken = 0;
        id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rd = '0;
        ex_mem_read = 0; ex_long_start = 0; mem_rd = '0; mem_reg_write = 0;
        mem_req = 0; mem_ready = 0; wb_rd = '0; wb_reg_write = 0; cnt_clr = 0;
    endtask

    task automatic rand_inputs(input int ready_pct);
        rst           = ($urandom_range(0, 99) < 2);
        id_valid      = ($urandom_range(0, 99) < 80);
        id_use_rs     = $urandom_range(0, 1);
        id_use_rt     = $urandom_range(0, 1);
        branch_taken  = ($urandom_range(0, 99) < 25);
        id_rs         = RW'($urandom_range(0, 3));
        id_rt         = RW'($urandom_range(0, 3));
        ex_rs         = RW'($urandom_range(0, 3));
        ex_rt         = RW'($urandom_range(0, 3));
        ex_rd         = RW'($urandom_range(0, 3));
        ex_mem_read   = ($urandom_range(0, 99) < 40);
        ex_long_start = ($urandom_range(0, 99) < 15);
        mem_rd        = RW'($urandom_range(0, 3));
        mem_reg_write = $urandom_range(0, 1);
        mem_req       = ($urandom_range(0, 99) < 30);
        mem_ready     = ($urandom_range(0, 99) < ready_pct);
        wb_rd         = RW'($urandom_range(0, 3));
        wb_reg_write  = $urandom_range(0, 1);
        cnt_clr       = ($urandom_range(0, 99) < 3);
    endtask

    initial begin
        quiet();
        rst = 1;
        m_long_left = 0; m_mem_wait = 0; m_err = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        apply_cycle();                 // reset-state outputs
        rst = 0;

        // forwarding priority and register 0
        ex_rs = 5'd3; mem_rd = 5'd3; mem_reg_write = 1; wb_rd = 5'd3; wb_reg_write = 1;
        #1 check("plan_fwd_exmem", int'(fwd_a), 2);
        apply_cycle();
        mem_rd = 5'd0;
        #1 check("plan_fwd_memwb", int'(fwd_a), 1);
        apply_cycle();
        ex_rs = 5'd0;
        #1 check("plan_fwd_zero", int'(fwd_a), 0);
        apply_cycle();
        quiet();

        // load-use beats a taken branch, branch flushes the next cycle
        id_valid = 1; ex_mem_read = 1; ex_rd = 5'd5; id_rs = 5'd5; id_use_rs = 1;
        branch_taken = 1;
        #1 check("plan_lu_bubble", int'(idex_bubble), 1);
        apply_cycle();
        ex_mem_read = 0;
        #1 check("plan_flush_after", int'(ifid_flush), 1);
        check("plan_cnt_one", int'(stall_cycles), 1);
        apply_cycle();
        quiet();

        // memory wait of 3 cycles, then a timeout
        mem_req = 1;
        repeat (3) apply_cycle();
        mem_ready = 1;
        apply_cycle();
        mem_ready = 0;
        repeat (TO - 1) apply_cycle();
        #1 check("plan_abort", int'(mem_abort), 1);
        apply_cycle();
        mem_req = 0;
        apply_cycle();

        // long op, a second start and a load-use while busy
        ex_long_start = 1;
        apply_cycle();
        id_valid = 1; ex_mem_read = 1; ex_rd = 5'd2; id_rt = 5'd2; id_use_rt = 1;
        repeat (LAT) apply_cycle();
        quiet();

        // reset in the middle of a memory wait
        mem_req = 1;
        repeat (3) apply_cycle();
        rst = 1;
        apply_cycle();
        rst = 0; mem_req = 0;
        apply_cycle();

        // saturate the counter, then clear it
        id_valid = 1; ex_mem_read = 1; ex_rd = 5'd7; id_rs = 5'd7; id_use_rs = 1;
        repeat (20) apply_cycle();
        #1 check("plan_cnt_sat", int'(stall_cycles), 15);
        cnt_clr = 1;
        apply_cycle();
        quiet();
        apply_cycle();

        for (int i = 0; i < 1500; i++) begin
            rand_inputs(50);
            apply_cycle();
        end
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(4);
            apply_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
